// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the scan FSM state enum, the default slot/blanking cycle counts and
// the active-low hex-to-7-segment pattern table (bit0 = segment a).
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  localparam int SLOT_CYC_DEF = 50000;
  localparam int DEAD_CYC_DEF = 500;

  // Entry n is the active-low pattern (g..a) for nibble n.
  // Letters use the usual mixed case: A b C d E F.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the scan controller and its digit mux / display.
// Latency: n/a (wiring only).
// Backpressure: none; display side is free-running.
//
// Signals: en, digit_mask, Y, DP (towards controller);
//          S, AN, SEG, SEG_DP, frame_tick (from controller);
//          bright (towards controller) only when SEG_SCAN_BRIGHT_EN is defined.
// master = controller side, slave = mux/display/system side.
interface seg_scan_ctrl_if;
  logic       en;
  logic [7:0] digit_mask;
  logic [3:0] Y;
  logic       DP;
  logic [2:0] S;
  logic [7:0] AN;
  logic [6:0] SEG;
  logic       SEG_DP;
  logic       frame_tick;
`ifdef SEG_SCAN_BRIGHT_EN
  logic [2:0] bright;
`endif

`ifdef SEG_SCAN_BRIGHT_EN
  modport master (
    input  en, digit_mask, Y, DP, bright,
    output S, AN, SEG, SEG_DP, frame_tick
  );
  modport slave (
    output en, digit_mask, Y, DP, bright,
    input  S, AN, SEG, SEG_DP, frame_tick
  );
`else
  modport master (
    input  en, digit_mask, Y, DP,
    output S, AN, SEG, SEG_DP, frame_tick
  );
  modport slave (
    output en, digit_mask, Y, DP,
    input  S, AN, SEG, SEG_DP, frame_tick
  );
`endif

endinterface

// File: rtl/seg_hex7.sv
// Hex nibble to active-low 7-segment pattern decoder.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports: nib (4-bit hex digit in), seg (7-bit pattern out, bit0 = a, active-low).
module seg_hex7
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment display scanner.
// Latency: S/AN registered off the FSM; SEG/SEG_DP one cycle after S changes.
// Backpressure: none; en=0 abandons the current slot and parks in IDLE.
//
// Ports: clk, rst_n (async active-low), io (seg_scan_ctrl_if.master):
//   en, digit_mask, Y, DP in; S, AN, SEG, SEG_DP, frame_tick out.
// Optional macro SEG_SCAN_BRIGHT_EN adds io.bright (3-bit PWM on-time in
// eighths of the ON phase); (SLOT_CYC-DEAD_CYC) must then be divisible by 8.
// Legal parameters: 2 <= DEAD_CYC < SLOT_CYC, so SEG settles before AN lights.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYC = SLOT_CYC_DEF,
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.master io
);

  localparam int ON_CYC = SLOT_CYC - DEAD_CYC;
  // One counter serves both phases; its largest value is below SLOT_CYC.
  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
`ifdef SEG_SCAN_BRIGHT_EN
  localparam int STEP = ON_CYC / 8;
`endif

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    s_q, s_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          tick_q, tick_d;
  logic          lit;
  logic [6:0]    seg_w;

  seg_hex7 u_hex7 (
    .nib (io.Y),
    .seg (seg_w)
  );

  // State register plus output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      an_q    <= an_d;
      // Y follows S through the external mux, so registering the decode
      // here lands SEG one cycle after S moves.
      seg_q   <= seg_w;
      dp_q    <= io.DP;
      tick_q  <= tick_d;
    end
  end

  // Next-state, counter, digit select and wrap detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    tick_d  = 1'b0;
    if (!io.en) begin
      // Abandon whatever slot is running; no wrap pulse.
      state_d = IDLE;
      cnt_d   = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          s_d     = '0;
        end
        BLANK: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            s_d     = s_q + 3'd1;
            tick_d  = (s_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          s_d     = '0;
        end
      endcase
    end
  end

  // Anode is decoded from the next-state values so the registered AN lines
  // up cycle-for-cycle with the state it belongs to. digit_mask is sampled
  // combinationally, so a change shows on the very next edge.
  always_comb begin
    lit = (state_d == ON) && io.digit_mask[s_d];
`ifdef SEG_SCAN_BRIGHT_EN
    lit = lit && (int'(cnt_d) < ((int'(io.bright) + 1) * STEP));
`endif
    an_d = lit ? ~(8'd1 << s_d) : 8'hFF;
  end

  assign io.S          = s_q;
  assign io.AN         = an_q;
  assign io.SEG        = seg_q;
  assign io.SEG_DP     = dp_q;
  assign io.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: scan timing, decode, masking, en drop,
// async reset and (with SEG_SCAN_BRIGHT_EN) brightness PWM.
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_BRIGHT_EN
  localparam int SLOT = 20;
`else
  localparam int SLOT = 16;
`endif
  localparam int DEAD = 4;
  localparam int ON   = SLOT - DEAD;

  // Digit contents presented by the modelled external mux, per S.
  localparam logic [7:0][3:0] VALS = {4'hF, 4'hd, 4'hb, 4'h5, 4'h8, 4'hC, 4'h2, 4'h1};
  localparam logic [7:0]      DPS  = 8'b1111_0111;  // digit 3 has its point lit
  // Hand-decoded active-low patterns for VALS.
  localparam logic [7:0][6:0] PATS = {7'h0E, 7'h21, 7'h03, 7'h12, 7'h00, 7'h46, 7'h24, 7'h79};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tot  = 0;
  int   n_pass = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.SLOT_CYC(SLOT), .DEAD_CYC(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.Y  = VALS[bus.S];
    bus.DP = DPS[bus.S];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Free-running scan from the edge that left IDLE; k=0 is the first
  // sample after that edge.
  task automatic scan(input int ncyc, input logic [7:0] mask, input int lit_len);
    for (int k = 0; k < ncyc; k++) begin
      int slot, ph, ps;
      logic [7:0] an_e;
      @(negedge clk);
      slot = (k / SLOT) % 8;
      ph   = k % SLOT;
      an_e = (ph >= DEAD && (ph - DEAD) < lit_len && mask[3'(slot)]) ?
             ~(8'd1 << slot) : 8'hFF;
      // SEG lags S by one cycle: on phase 0 it still shows the prior digit.
      ps   = (ph == 0 && k > 0) ? (slot + 7) % 8 : slot;
      check("scan_S",    32'(bus.S),          32'(slot));
      check("scan_AN",   32'(bus.AN),         32'(an_e));
      check("scan_tick", 32'(bus.frame_tick), 32'(k > 0 && (k % (8 * SLOT)) == 0));
      check("scan_SEG",  32'(bus.SEG),        32'(PATS[3'(ps)]));
      check("scan_DP",   32'(bus.SEG_DP),     32'(DPS[3'(ps)]));
      if (slot == 3 && ph == 1) begin
        check("seg_y8_s3",  32'(bus.SEG),    32'h00);
        check("segdp_s3",   32'(bus.SEG_DP), 32'h0);
      end
      if (slot == 7 && ph == 1)
        check("seg_yF_s7", 32'(bus.SEG), 32'h0E);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_S"},    32'(bus.S),          32'h0);
    check({tag, "_AN"},   32'(bus.AN),         32'hFF);
    check({tag, "_SEG"},  32'(bus.SEG),        32'h7F);
    check({tag, "_DP"},   32'(bus.SEG_DP),     32'h1);
    check({tag, "_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

`ifdef SEG_SCAN_BRIGHT_EN
  task automatic bright_slot(input logic [2:0] b, input int exp_cnt);
    int cnt, first;
    bus.en = 1'b0;
    @(negedge clk);
    bus.bright = b;
    bus.en     = 1'b1;
    @(posedge clk);
    cnt   = 0;
    first = -1;
    for (int k = 0; k < SLOT; k++) begin
      @(negedge clk);
      if (bus.AN != 8'hFF) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("bright_on_cnt",   32'(cnt),   32'(exp_cnt));
    check("bright_first_on", 32'(first), 32'(DEAD));
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.en         = 1'b0;
    bus.digit_mask = 8'hFF;
`ifdef SEG_SCAN_BRIGHT_EN
    bus.bright     = 3'd7;
`endif
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_S",  32'(bus.S),  32'h0);
    check("idle_AN", 32'(bus.AN), 32'hFF);

    // Full-mask scan for two frames.
    bus.en = 1'b1;
    @(posedge clk);
    scan(16 * SLOT, 8'hFF, ON);

    // One cycle of en=0 returns to IDLE without a wrap pulse.
    bus.en = 1'b0;
    @(negedge clk);
    check("drop_AN",   32'(bus.AN),         32'hFF);
    check("drop_S",    32'(bus.S),          32'h0);
    check("drop_tick", 32'(bus.frame_tick), 32'h0);

    // Digit 2 masked: dark for its whole slot but slot timing unchanged.
    bus.digit_mask = 8'b1111_1011;
    bus.en         = 1'b1;
    @(posedge clk);
    scan(8 * SLOT, 8'b1111_1011, ON);

    // Drop en in the ON phase of digit 5.
    bus.digit_mask = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < 16 * SLOT && !found; i++) begin
      @(negedge clk);
      if (bus.S == 3'd5 && bus.AN != 8'hFF) found = 1'b1;
    end
    check("find_s5_on", 32'(found), 32'h1);
    bus.en = 1'b0;
    @(negedge clk);
    check("en_drop_AN", 32'(bus.AN), 32'hFF);
    check("en_drop_S",  32'(bus.S),  32'h0);
    bus.en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < DEAD; i++) begin
      @(negedge clk);
      check("reen_blank_AN", 32'(bus.AN), 32'hFF);
    end
    @(negedge clk);
    check("reen_on_AN", 32'(bus.AN), 32'hFE);

    // Async reset in the middle of digit 1's ON phase.
    found = 1'b0;
    for (int i = 0; i < 16 * SLOT && !found; i++) begin
      @(negedge clk);
      if (bus.S == 3'd1 && bus.AN != 8'hFF) found = 1'b1;
    end
    check("find_s1_on", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_mid_held");
    // en is already high: the first edge after release starts BLANK.
    rst_n = 1'b1;
    @(posedge clk);
    scan(2 * SLOT, 8'hFF, ON);

`ifdef SEG_SCAN_BRIGHT_EN
    bright_slot(3'd1, 4);
    bright_slot(3'd7, ON);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SLOT_CYC, default 50000: clock cycles per digit slot.
REQ-002 SHALL have parameter DEAD_CYC, default 500: blanking cycles at the start of each slot.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port digit_mask  input  8  per-digit enable; bit i=1 means digit i may light.
REQ-007 SHALL have port Y  input  4  hex nibble from the external 8:1 digit mux.
REQ-008 SHALL have port DP  input  1  decimal point from the digit mux; active-low.
REQ-009 SHALL have port S  output  3  digit select to the mux; registered.
REQ-010 SHALL have port AN  output  8  digit anodes; one-hot active-low; registered.
REQ-011 SHALL have port SEG  output  7  segments a..g (bit0=a); active-low; registered.
REQ-012 SHALL have port SEG_DP  output  1  decimal point; active-low; registered.
REQ-013 SHALL have port frame_tick  output  1  one-cycle pulse at the end of the digit-7 slot.

Function
REQ-014 SHALL implement states IDLE, BLANK and ON.
REQ-015 IDLE SHALL hold AN=8'hFF, S=0 and clear all counters; it SHALL go to BLANK on the first cycle with en=1.
REQ-016 BLANK SHALL last exactly DEAD_CYC cycles with AN=8'hFF, then go to ON.
REQ-017 ON SHALL last SLOT_CYC-DEAD_CYC cycles; at its final cycle S SHALL increment modulo 8 (7->0) and the state SHALL go to BLANK.
REQ-018 In ON, AN[S] SHALL be 0 and all other AN bits 1, except that AN SHALL stay 8'hFF when digit_mask[S]=0; a masked slot still consumes full time.
REQ-019 SEG SHALL be the hex-to-7-segment decode of Y, and SEG_DP SHALL equal DP, both registered with 1-cycle latency after S changes.
REQ-020 Hex decode SHALL cover 0-9 and A,b,C,d,E,F.
REQ-021 frame_tick SHALL be 1 for exactly the cycle in which S wraps from 7 to 0.
REQ-022 When en=0 in any state, the next cycle SHALL be IDLE; an in-progress slot SHALL be abandoned, not completed.
REQ-023 A digit_mask change SHALL take effect on the next clock edge.
REQ-024 Legal parameters SHALL satisfy 2 <= DEAD_CYC < SLOT_CYC, so that SEG has settled before any anode lights.

Reset
REQ-025 While rst_n=0, outputs SHALL be S=0, AN=8'hFF, SEG=7'h7F, SEG_DP=1 and frame_tick=0, the state SHALL be IDLE and all counters SHALL be 0.
REQ-026 After rst_n deassertion, the first BLANK SHALL start on the first rising edge with en=1.

Configuration
REQ-027 Macro SEG_SCAN_BRIGHT_EN, when defined, SHALL add input bright (width 3) and require (SLOT_CYC-DEAD_CYC) divisible by 8.
REQ-028 With SEG_SCAN_BRIGHT_EN defined, the anode SHALL light only while the ON-phase counter < (bright+1)*((SLOT_CYC-DEAD_CYC)/8); bright=7 gives full on-time.
REQ-029 Without SEG_SCAN_BRIGHT_EN, the bright port SHALL be absent and the anode SHALL light for the whole ON phase.

Structure
REQ-030 Package seg_scan_pkg SHALL hold the state enum, the default SLOT_CYC/DEAD_CYC constants and the 16-entry segment pattern table.
REQ-031 Sub-module seg_hex7 SHALL be purely combinational, mapping 4-bit nibble to 7-bit active-low pattern; it SHALL be instantiated once.

Verification
REQ-032 Bench SHALL cover: SLOT_CYC=16, DEAD_CYC=4, en=1, mask=8'hFF -> S steps 0..7 every 16 cycles; AN[S]=0 for 12 cycles per slot; AN=8'hFF for 4 cycles; frame_tick every 128 cycles.
REQ-033 Bench SHALL cover: Y=4'h8 with S=3, DP=0 -> SEG=7'h00 and SEG_DP=0 one cycle after S=3; Y=4'hF -> SEG=7'h0E.
REQ-034 Bench SHALL cover: mask=8'b1111_1011 -> AN stays 8'hFF throughout slot 2, and slot 2 still lasts 16 cycles.
REQ-035 Bench SHALL cover: en dropped mid-ON at S=5 -> next cycle AN=8'hFF and S=0; en re-raised -> BLANK of 4 cycles, then AN=8'hFE.
REQ-036 Bench SHALL cover: rst_n pulsed low mid-slot -> outputs immediately match REQ-025 without waiting for a clock edge.
REQ-037 Bench SHALL cover: with SEG_SCAN_BRIGHT_EN, bright=1, SLOT_CYC=20, DEAD_CYC=4 -> anode low 4 of 16 ON cycles; bright=7 -> anode low all 16.
